systolic_array_4x4: RTL and testbench

SYSTOLIC_ARRAY_4X4 -- requirements
Module: systolic_array_4x4

---
 rtl/tpu_pkg.sv | 29 ++
 rtl/sa_pe.sv | 30 +++
 rtl/systolic_array_4x4.sv | 130 +++++++++++++
 tb/tb_systolic_array_4x4.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants, FSM state type and operand skew helper
// for the 4x4 int8 systolic matrix-multiply tile.
package tpu_pkg;

   localparam int DATA_BITS  = 32;
   localparam int DATAC_BITS = 128;
   localparam int SA_DIM     = 4;
   localparam int SA_LATENCY = 11;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } sa_state_e;

   typedef logic [SA_DIM-1:0][7:0] sa_vec_t;

   // Operand k = cnt - off, zero when k falls outside 0..3.
   function automatic logic [7:0] skew_pick(
      input sa_vec_t    v,
      input logic [3:0] cnt,
      input logic [1:0] off
   );
      logic [4:0] k;
      k = {1'b0, cnt} - {3'b000, off};
      skew_pick = (k < 5'd4) ? v[k[1:0]] : 8'd0;
   endfunction

endpackage

// File: rtl/sa_pe.sv
// Systolic processing element: registered A/B pass-through
// plus a signed int8 MAC into a wrapping 32-bit accumulator.
module sa_pe (
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  a_in,
   input  logic [7:0]  b_in,
   output logic [7:0]  a_out,
   output logic [7:0]  b_out,
   output logic [31:0] acc
);

   logic signed [15:0] prod;

   assign prod = $signed(a_in) * $signed(b_in);

   always_ff @(posedge clk) begin
      if (clr) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else if (en) begin
         a_out <= a_in;
         b_out <= b_in;
         acc   <= acc + {{16{prod[15]}}, prod};
      end
   end

endmodule

// File: rtl/systolic_array_4x4.sv
// 4x4 output-stationary systolic array: one int8 tile
// C = A*B per run, done on the 11th edge after start.
module systolic_array_4x4 #(
   parameter int DATA_BITS  = tpu_pkg::DATA_BITS,
   parameter int DATAC_BITS = tpu_pkg::DATAC_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sa_rst_n,
   input  logic [DATA_BITS-1:0]  a0,
   input  logic [DATA_BITS-1:0]  a1,
   input  logic [DATA_BITS-1:0]  a2,
   input  logic [DATA_BITS-1:0]  a3,
   input  logic [DATA_BITS-1:0]  b0,
   input  logic [DATA_BITS-1:0]  b1,
   input  logic [DATA_BITS-1:0]  b2,
   input  logic [DATA_BITS-1:0]  b3,
   output logic [DATAC_BITS-1:0] c0,
   output logic [DATAC_BITS-1:0] c1,
   output logic [DATAC_BITS-1:0] c2,
   output logic [DATAC_BITS-1:0] c3,
   output logic                  done
);

   import tpu_pkg::*;

   sa_state_e  state;
   logic [3:0] cnt;
   logic       run;
   logic       clr;

   // tile_a[r][k] = A[r][k], tile_b[c][k] = B[k][c]
   sa_vec_t [SA_DIM-1:0] tile_a;
   sa_vec_t [SA_DIM-1:0] tile_b;

   logic [SA_DIM-1:0][DATA_BITS-1:0] a_w;
   logic [SA_DIM-1:0][DATA_BITS-1:0] b_w;

   logic [SA_DIM-1:0][SA_DIM:0][7:0]   a_h;
   logic [SA_DIM:0][SA_DIM-1:0][7:0]   b_v;
   logic [SA_DIM-1:0][SA_DIM-1:0][31:0] acc;

   logic unused_edge;

   assign a_w = {a3, a2, a1, a0};
   assign b_w = {b3, b2, b1, b0};

   assign run = (state == RUN) && sa_rst_n;
   assign clr = rst || !sa_rst_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         done   <= 1'b0;
         tile_a <= '0;
         tile_b <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt  <= '0;
               done <= 1'b0;
               if (sa_rst_n) begin
                  state <= RUN;
                  for (int i = 0; i < SA_DIM; i++) begin
                     for (int k = 0; k < SA_DIM; k++) begin
                        tile_a[i][k] <= a_w[k][8*i +: 8];
                        tile_b[i][k] <= b_w[k][8*i +: 8];
                     end
                  end
               end
            end
            RUN: begin
               if (!sa_rst_n) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == 4'(SA_LATENCY - 2)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               if (!sa_rst_n) begin
                  state <= IDLE;
                  cnt   <= '0;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Row r of A and column c of B enter delayed by r / c cycles.
   for (genvar i = 0; i < SA_DIM; i++) begin : g_feed
      assign a_h[i][0] = run ? skew_pick(tile_a[i], cnt, 2'(i)) : 8'd0;
      assign b_v[0][i] = run ? skew_pick(tile_b[i], cnt, 2'(i)) : 8'd0;
   end

   for (genvar r = 0; r < SA_DIM; r++) begin : g_row
      for (genvar c = 0; c < SA_DIM; c++) begin : g_col
         sa_pe u_pe (
            .clk   (clk),
            .clr   (clr),
            .en    (run),
            .a_in  (a_h[r][c]),
            .b_in  (b_v[r][c]),
            .a_out (a_h[r][c+1]),
            .b_out (b_v[r+1][c]),
            .acc   (acc[r][c])
         );
      end
   end

   assign unused_edge = ^{a_h[0][SA_DIM], a_h[1][SA_DIM],
                          a_h[2][SA_DIM], a_h[3][SA_DIM],
                          b_v[SA_DIM]};

   assign c0 = DATAC_BITS'(acc[0]);
   assign c1 = DATAC_BITS'(acc[1]);
   assign c2 = DATAC_BITS'(acc[2]);
   assign c3 = DATAC_BITS'(acc[3]);

endmodule

// File: tb/tb_systolic_array_4x4.sv
// Scoreboard bench for systolic_array_4x4: directed tiles,
// abort/reset cases and random tiles against a sum model.
module tb_systolic_array_4x4;

   typedef logic [3:0][3:0][7:0] mat_t;
   typedef logic [3:0][127:0]    res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         sa_rst_n;
   logic [31:0]  a0, a1, a2, a3;
   logic [31:0]  b0, b1, b2, b3;
   logic [127:0] c0, c1, c2, c3;
   logic         done;

   res_t exp_q[$];
   res_t mon_e;
   logic done_q = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   systolic_array_4x4 dut (
      .clk      (clk),
      .rst      (rst),
      .sa_rst_n (sa_rst_n),
      .a0       (a0),
      .a1       (a1),
      .a2       (a2),
      .a3       (a3),
      .b0       (b0),
      .b1       (b1),
      .b2       (b2),
      .b3       (b3),
      .c0       (c0),
      .c1       (c1),
      .c2       (c2),
      .c3       (c3),
      .done     (done)
   );

   task automatic check(input string name,
                        input logic [127:0] act,
                        input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   function automatic res_t model(input mat_t am, input mat_t bm);
      res_t res;
      int   s;
      res = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int k = 0; k < 4; k++)
               s += int'($signed(am[r][k])) * int'($signed(bm[k][c]));
            res[r][32*c +: 32] = s;
         end
      end
      return res;
   endfunction

   task automatic drive(input mat_t am, input mat_t bm);
      logic [3:0][31:0] aw;
      logic [3:0][31:0] bw;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            aw[k][8*i +: 8] = am[i][k];
            bw[k][8*i +: 8] = bm[k][i];
         end
      end
      a0 = aw[0]; a1 = aw[1]; a2 = aw[2]; a3 = aw[3];
      b0 = bw[0]; b1 = bw[1]; b2 = bw[2]; b3 = bw[3];
   endtask

   task automatic scramble_inputs();
      a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
      b0 = $urandom; b1 = $urandom; b2 = $urandom; b3 = $urandom;
   endtask

   task automatic check_zero(input string name);
      check({name, "_c0"}, c0, 128'd0);
      check({name, "_c1"}, c1, 128'd0);
      check({name, "_c2"}, c2, 128'd0);
      check({name, "_c3"}, c3, 128'd0);
      check({name, "_done"}, 128'(done), 128'd0);
   endtask

   task automatic run_tile(input mat_t am, input mat_t bm,
                           input res_t exp_r, input int hold,
                           input bit scr, input bit rst_done);
      int hi;
      hi = 0;
      exp_q.push_back(exp_r);
      @(negedge clk);
      drive(am, bm);
      sa_rst_n = 1'b1;
      for (int e = 1; e <= hold; e++) begin
         @(posedge clk);
         #1;
         if (e == 1 && scr) scramble_inputs();
         if (e == 10) check("latency_early", 128'(done), 128'd0);
         if (e == 11) check("latency", 128'(done), 128'd1);
         if (e >= 11 && done) hi++;
      end
      if (rst_done) begin
         rst = 1'b1;
         @(posedge clk);
         #1;
         check_zero("rst_in_done");
         rst = 1'b0;
         sa_rst_n = 1'b0;
         @(posedge clk);
         #1;
      end else begin
         sa_rst_n = 1'b0;
         @(posedge clk);
         #1;
         check("done_clear", 128'(done), 128'd0);
         check("pulse_len", 128'(hi), 128'(hold - 10));
      end
   endtask

   always @(negedge clk) begin
      if (done && !done_q) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 want no result");
         end else begin
            mon_e = exp_q.pop_front();
            check("row0", c0, mon_e[0]);
            check("row1", c1, mon_e[1]);
            check("row2", c2, mon_e[2]);
            check("row3", c3, mon_e[3]);
         end
      end
      done_q = done;
   end

   mat_t id_a, id_b, ex_a, ex_b, ng_a, ng_b, r_a, r_b;
   res_t id_c, ex_c, ng_c;
   bit   seen;

   initial begin
      rst = 1'b1;
      sa_rst_n = 1'b0;
      drive('0, '0);
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            id_a[i][k] = (i == k) ? 8'd1 : 8'd0;
            id_b[k][i] = 8'(4 * k + i + 1);
            ng_a[i][k] = 8'(i + 1);
            ng_b[k][i] = 8'hFF;
         end
      end
      id_c[0] = 128'h00000004_00000003_00000002_00000001;
      id_c[1] = 128'h00000008_00000007_00000006_00000005;
      id_c[2] = 128'h0000000C_0000000B_0000000A_00000009;
      id_c[3] = 128'h00000010_0000000F_0000000E_0000000D;
      ng_c[0] = {4{32'hFFFFFFFC}};
      ng_c[1] = {4{32'hFFFFFFF8}};
      ng_c[2] = {4{32'hFFFFFFF4}};
      ng_c[3] = {4{32'hFFFFFFF0}};

      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      run_tile(id_a, id_b, id_c, 11, 1'b0, 1'b0);

      ex_a = {16{8'h80}};
      ex_b = {16{8'h80}};
      ex_c = {4{{4{32'h00010000}}}};
      run_tile(ex_a, ex_b, ex_c, 14, 1'b0, 1'b0);

      ex_a = {16{8'h7F}};
      ex_c = {4{{4{32'hFFFF0200}}}};
      run_tile(ex_a, ex_b, ex_c, 12, 1'b0, 1'b0);

      run_tile(ng_a, ng_b, ng_c, 11, 1'b0, 1'b0);

      // abort: sa_rst_n sampled low on edge 6
      @(negedge clk);
      drive(id_a, id_b);
      sa_rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      sa_rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_zero("abort");
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("abort_no_done", 128'(seen), 128'd0);
      run_tile(ng_a, ng_b, ng_c, 11, 1'b0, 1'b0);

      // rst sampled on edge 8 of a run
      @(negedge clk);
      drive(id_a, id_b);
      sa_rst_n = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      sa_rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_zero("rst_in_run");
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) seen = 1'b1;
      end
      check("rst_run_no_done", 128'(seen), 128'd0);

      run_tile(id_a, id_b, id_c, 12, 1'b1, 1'b1);
      run_tile(ex_a, ex_b, ex_c, 11, 1'b1, 1'b0);

      for (int t = 0; t < 1000; t++) begin
         for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
               r_a[i][k] = 8'($urandom);
               r_b[i][k] = 8'($urandom);
            end
         end
         run_tile(r_a, r_b, model(r_a, r_b),
                  11 + int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'b0);
      end

      repeat (2) @(posedge clk);
      #1;
      check("queue_empty", 128'(exp_q.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
